video_timing_gen: RTL and testbench

- Generates the 1280x720@60 pixel raster (74.25 MHz pixel clock) that drives color_gen's h_count/v_count inputs.
- Produces raw sync/blank decode aligned with the counters.
- Produces copies of that decode delayed by a configurable number of cycles, so they line up with color_gen's registered colour output at the HDMI/TMDS encoder.
- Emits a once-per-frame strobe and a frame counter for animation logic.

---
 rtl/video_timing_gen.sv | 100 ++++++++++
 tb/tb_video_timing_gen.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, sync and blank decode,
// matched-latency delayed copies and a per-frame strobe with frame counter.
module video_timing_gen #(
    parameter int ACTIVE_H   = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int ACTIVE_V   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter int SYNC_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] h_count,
    output logic [9:0]  v_count,
    output logic        active_draw,
    output logic        h_sync,
    output logic        v_sync,
    output logic        new_frame,
    output logic [5:0]  frame_count,
    output logic        active_draw_dly,
    output logic        h_sync_dly,
    output logic        v_sync_dly
);

    localparam int H_TOTAL = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2048) begin : g_h_chk
        $error("H_TOTAL exceeds 11-bit counter range");
    end
    if (V_TOTAL > 1024) begin : g_v_chk
        $error("V_TOTAL exceeds 10-bit counter range");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_d_chk
        $error("SYNC_DELAY must be 0..15");
    end

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(ACTIVE_H);
    localparam logic [10:0] HS_BEG = 11'(ACTIVE_H + H_FP);
    localparam logic [10:0] HS_END = 11'(ACTIVE_H + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(ACTIVE_V);
    localparam logic [9:0]  VS_BEG = 10'(ACTIVE_V + V_FP);
    localparam logic [9:0]  VS_END = 10'(ACTIVE_V + V_FP + V_SYNC);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count <= h_count + 11'd1;
        end
    end

    // Decoded straight from the count registers: zero skew to h/v_count.
    assign active_draw = (h_count < H_ACT) && (v_count < V_ACT);
    assign h_sync      = (h_count >= HS_BEG) && (h_count < HS_END);
    assign v_sync      = (v_count >= VS_BEG) && (v_count < VS_END);
    assign new_frame   = (h_count == H_ACT) && (v_count == V_ACT);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (new_frame) begin
            frame_count <= frame_count + 6'd1;
        end
    end

    logic [2:0] dly_in;
    assign dly_in = {active_draw, h_sync, v_sync};

    if (SYNC_DELAY == 0) begin : g_pass
        assign {active_draw_dly, h_sync_dly, v_sync_dly} = dly_in;
    end else begin : g_pipe
        logic [2:0] sr [SYNC_DELAY];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < SYNC_DELAY; i++) begin
                    sr[i] <= 3'b000;
                end
            end else begin
                sr[0] <= dly_in;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
        end

        assign {active_draw_dly, h_sync_dly, v_sync_dly} = sr[SYNC_DELAY-1];
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: two reduced-raster instances (delay 2 and 0) and one
// full 1280x720 instance, checked against hand-computed positions.
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Reduced raster: line 25 cycles, frame 13 lines (325 cycles).
    // h_sync h=18..20, v_sync v=9..10, new_frame at (16,8).
    logic [10:0] s_h, z_h, d_h;
    logic [9:0]  s_v, z_v, d_v;
    logic        s_ad, s_hs, s_vs, s_nf, s_add, s_hsd, s_vsd;
    logic        z_ad, z_hs, z_vs, z_nf, z_add, z_hsd, z_vsd;
    logic        d_ad, d_hs, d_vs, d_nf, d_add, d_hsd, d_vsd;
    logic [5:0]  s_fc, z_fc, d_fc;

    video_timing_gen #(
        .ACTIVE_H(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .ACTIVE_V(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_DELAY(2)
    ) dut_s (
        .clk(clk), .rst(rst), .h_count(s_h), .v_count(s_v),
        .active_draw(s_ad), .h_sync(s_hs), .v_sync(s_vs),
        .new_frame(s_nf), .frame_count(s_fc),
        .active_draw_dly(s_add), .h_sync_dly(s_hsd), .v_sync_dly(s_vsd)
    );

    video_timing_gen #(
        .ACTIVE_H(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .ACTIVE_V(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_DELAY(0)
    ) dut_z (
        .clk(clk), .rst(rst), .h_count(z_h), .v_count(z_v),
        .active_draw(z_ad), .h_sync(z_hs), .v_sync(z_vs),
        .new_frame(z_nf), .frame_count(z_fc),
        .active_draw_dly(z_add), .h_sync_dly(z_hsd), .v_sync_dly(z_vsd)
    );

    video_timing_gen dut_d (
        .clk(clk), .rst(rst), .h_count(d_h), .v_count(d_v),
        .active_draw(d_ad), .h_sync(d_hs), .v_sync(d_vs),
        .new_frame(d_nf), .frame_count(d_fc),
        .active_draw_dly(d_add), .h_sync_dly(d_hsd), .v_sync_dly(d_vsd)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_chk++;
        if ({s_h, s_v} !== 21'd0)
            $display("FAIL rst_hv got %0d,%0d want 0,0", s_h, s_v);
        else n_pass++;
        n_chk++;
        if ({s_ad, s_hs, s_vs, s_nf} !== 4'b1000)
            $display("FAIL rst_dec got %b want 1000",
                     {s_ad, s_hs, s_vs, s_nf});
        else n_pass++;
        n_chk++;
        if ({s_add, s_hsd, s_vsd, s_fc} !== 9'd0)
            $display("FAIL rst_dly_fc got %b/%0d want 000/0",
                     {s_add, s_hsd, s_vsd}, s_fc);
        else n_pass++;
        n_chk++;
        if ({z_add, z_hsd, z_vsd} !== 3'b100)
            $display("FAIL rst_zdly got %b want 100",
                     {z_add, z_hsd, z_vsd});
        else n_pass++;
        n_chk++;
        if ({d_h, d_v, d_add} !== 22'd0)
            $display("FAIL rst_def got %0d,%0d,%b want 0,0,0",
                     d_h, d_v, d_add);
        else n_pass++;
        rst = 1'b0;
        cyc = 0;
        n_chk++;
        if ({s_h, s_v, s_ad, s_fc} !== {11'd0, 10'd0, 1'b1, 6'd0})
            $display("FAIL rel_0 got %0d,%0d,%b,%0d want 0,0,1,0",
                     s_h, s_v, s_ad, s_fc);
        else n_pass++;
        goto(1);
        n_chk++;
        if ({s_h, s_v, d_h, d_v} !== {11'd1, 10'd0, 11'd1, 10'd0})
            $display("FAIL rel_1 got %0d,%0d/%0d,%0d want 1,0/1,0",
                     s_h, s_v, d_h, d_v);
        else n_pass++;
    endtask

    task automatic test_line_wrap;
        goto(15);
        n_chk++;
        if ({s_h, s_ad} !== {11'd15, 1'b1})
            $display("FAIL lw_15 got %0d,%b want 15,1", s_h, s_ad);
        else n_pass++;
        goto(16);
        n_chk++;
        if ({s_h, s_ad} !== {11'd16, 1'b0})
            $display("FAIL lw_16 got %0d,%b want 16,0", s_h, s_ad);
        else n_pass++;
        goto(24);
        n_chk++;
        if ({s_h, s_v} !== {11'd24, 10'd0})
            $display("FAIL lw_24 got %0d,%0d want 24,0", s_h, s_v);
        else n_pass++;
        goto(25);
        n_chk++;
        if ({s_h, s_v, s_ad} !== {11'd0, 10'd1, 1'b1})
            $display("FAIL lw_wrap got %0d,%0d,%b want 0,1,1",
                     s_h, s_v, s_ad);
        else n_pass++;
    endtask

    task automatic test_delay;
        goto(41);
        n_chk++;
        if ({z_ad, z_add} !== 2'b00)
            $display("FAIL z_ad got %b want 00", {z_ad, z_add});
        else n_pass++;
        goto(42);
        n_chk++;
        if ({s_ad, s_add} !== 2'b01)
            $display("FAIL dly_ad42 got %b want 01", {s_ad, s_add});
        else n_pass++;
        goto(43);
        n_chk++;
        if ({s_add, s_hs, s_hsd, z_hsd} !== 4'b0101)
            $display("FAIL dly_43 got %b want 0101",
                     {s_add, s_hs, s_hsd, z_hsd});
        else n_pass++;
        goto(45);
        n_chk++;
        if (s_hsd !== 1'b1)
            $display("FAIL dly_hs45 got %b want 1", s_hsd);
        else n_pass++;
        goto(47);
        n_chk++;
        if ({s_hs, s_hsd} !== 2'b01)
            $display("FAIL dly_hs47 got %b want 01", {s_hs, s_hsd});
        else n_pass++;
        goto(48);
        n_chk++;
        if (s_hsd !== 1'b0)
            $display("FAIL dly_hs48 got %b want 0", s_hsd);
        else n_pass++;
        goto(51);
        n_chk++;
        if ({s_ad, s_add} !== 2'b10)
            $display("FAIL dly_ad51 got %b want 10", {s_ad, s_add});
        else n_pass++;
        goto(52);
        n_chk++;
        if (s_add !== 1'b1)
            $display("FAIL dly_ad52 got %b want 1", s_add);
        else n_pass++;
    endtask

    task automatic test_frame_strobe;
        goto(215);
        n_chk++;
        if ({s_nf, s_fc} !== 7'd0)
            $display("FAIL nf_215 got %b,%0d want 0,0", s_nf, s_fc);
        else n_pass++;
        goto(216);
        n_chk++;
        if ({s_h, s_v, s_nf, s_fc} !== {11'd16, 10'd8, 1'b1, 6'd0})
            $display("FAIL nf_216 got %0d,%0d,%b,%0d want 16,8,1,0",
                     s_h, s_v, s_nf, s_fc);
        else n_pass++;
        goto(217);
        n_chk++;
        if ({s_nf, s_fc} !== {1'b0, 6'd1})
            $display("FAIL nf_217 got %b,%0d want 0,1", s_nf, s_fc);
        else n_pass++;
        goto(324);
        n_chk++;
        if ({s_h, s_v} !== {11'd24, 10'd12})
            $display("FAIL fr_end got %0d,%0d want 24,12", s_h, s_v);
        else n_pass++;
        goto(325);
        n_chk++;
        if ({s_h, s_v, s_fc} !== {11'd0, 10'd0, 6'd1})
            $display("FAIL fr_wrap got %0d,%0d,%0d want 0,0,1",
                     s_h, s_v, s_fc);
        else n_pass++;
    endtask

    task automatic test_sync_windows;
        int hs_n = 0, vs_n = 0, ad_n = 0, nf_n = 0;
        int hsd_n = 0, vsd_n = 0, bad_n = 0, zbad_n = 0;
        goto(325);
        for (int i = 0; i < 325; i++) begin
            if (i > 0) goto(cyc + 1);
            hs_n  += int'(s_hs);
            vs_n  += int'(s_vs);
            ad_n  += int'(s_ad);
            nf_n  += int'(s_nf);
            hsd_n += int'(s_hsd);
            vsd_n += int'(s_vsd);
            if (s_hs && (s_h < 11'd18 || s_h > 11'd20)) bad_n++;
            if (s_vs && (s_v < 10'd9 || s_v > 10'd10)) bad_n++;
            if ({z_add, z_hsd, z_vsd} !== {z_ad, z_hs, z_vs}) zbad_n++;
        end
        n_chk++;
        if ({hs_n, vs_n} !== {32'd39, 32'd50})
            $display("FAIL sw_cnt got hs=%0d vs=%0d want 39,50",
                     hs_n, vs_n);
        else n_pass++;
        n_chk++;
        if ({ad_n, nf_n} !== {32'd128, 32'd1})
            $display("FAIL sw_ad_nf got %0d,%0d want 128,1", ad_n, nf_n);
        else n_pass++;
        n_chk++;
        if ({hsd_n, vsd_n} !== {32'd39, 32'd50})
            $display("FAIL sw_dly got %0d,%0d want 39,50", hsd_n, vsd_n);
        else n_pass++;
        n_chk++;
        if ({bad_n, zbad_n} !== 64'd0)
            $display("FAIL sw_window got out=%0d zdiff=%0d want 0,0",
                     bad_n, zbad_n);
        else n_pass++;
    endtask

    task automatic test_default_raster;
        goto(1279);
        n_chk++;
        if (d_ad !== 1'b1)
            $display("FAIL def_1279 got %b want 1", d_ad);
        else n_pass++;
        goto(1280);
        n_chk++;
        if ({d_h, d_ad} !== {11'd1280, 1'b0})
            $display("FAIL def_1280 got %0d,%b want 1280,0", d_h, d_ad);
        else n_pass++;
        goto(1281);
        n_chk++;
        if (d_add !== 1'b1)
            $display("FAIL def_dly1281 got %b want 1", d_add);
        else n_pass++;
        goto(1282);
        n_chk++;
        if (d_add !== 1'b0)
            $display("FAIL def_dly1282 got %b want 0", d_add);
        else n_pass++;
        goto(1389);
        n_chk++;
        if (d_hs !== 1'b0)
            $display("FAIL def_hs1389 got %b want 0", d_hs);
        else n_pass++;
        goto(1390);
        n_chk++;
        if ({d_hs, d_vs} !== 2'b10)
            $display("FAIL def_hs1390 got %b want 10", {d_hs, d_vs});
        else n_pass++;
        goto(1429);
        n_chk++;
        if (d_hs !== 1'b1)
            $display("FAIL def_hs1429 got %b want 1", d_hs);
        else n_pass++;
        goto(1430);
        n_chk++;
        if (d_hs !== 1'b0)
            $display("FAIL def_hs1430 got %b want 0", d_hs);
        else n_pass++;
        goto(1649);
        n_chk++;
        if ({d_h, d_v} !== {11'd1649, 10'd0})
            $display("FAIL def_1649 got %0d,%0d want 1649,0", d_h, d_v);
        else n_pass++;
        goto(1650);
        n_chk++;
        if ({d_h, d_v} !== {11'd0, 10'd1})
            $display("FAIL def_wrap got %0d,%0d want 0,1", d_h, d_v);
        else n_pass++;
    endtask

    task automatic test_fc_wrap;
        goto(20691);
        n_chk++;
        if ({s_nf, s_fc} !== {1'b1, 6'd63})
            $display("FAIL fc_63 got %b,%0d want 1,63", s_nf, s_fc);
        else n_pass++;
        goto(20692);
        n_chk++;
        if (s_fc !== 6'd0)
            $display("FAIL fc_wrap got %0d want 0", s_fc);
        else n_pass++;
    endtask

    task automatic test_mid_reset;
        goto(20907);
        n_chk++;
        if ({s_h, s_v, s_add} !== {11'd7, 10'd4, 1'b1})
            $display("FAIL mr_pre got %0d,%0d,%b want 7,4,1",
                     s_h, s_v, s_add);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        n_chk++;
        if ({s_h, s_v, d_h, d_v} !== 42'd0)
            $display("FAIL mr_hv got %0d,%0d/%0d,%0d want 0,0/0,0",
                     s_h, s_v, d_h, d_v);
        else n_pass++;
        n_chk++;
        if ({s_add, s_hsd, s_vsd, s_fc} !== 9'd0)
            $display("FAIL mr_dly got %b/%0d want 000/0",
                     {s_add, s_hsd, s_vsd}, s_fc);
        else n_pass++;
        goto(1);
        n_chk++;
        if ({s_h, s_add} !== {11'd1, 1'b0})
            $display("FAIL mr_1 got %0d,%b want 1,0", s_h, s_add);
        else n_pass++;
        goto(2);
        n_chk++;
        if (s_add !== 1'b1)
            $display("FAIL mr_2 got %b want 1", s_add);
        else n_pass++;
        goto(25);
        n_chk++;
        if ({s_h, s_v} !== {11'd0, 10'd1})
            $display("FAIL mr_wrap got %0d,%0d want 0,1", s_h, s_v);
        else n_pass++;
        goto(215);
        n_chk++;
        if (s_nf !== 1'b0)
            $display("FAIL mr_nf215 got %b want 0", s_nf);
        else n_pass++;
        goto(216);
        n_chk++;
        if ({s_nf, s_fc} !== {1'b1, 6'd0})
            $display("FAIL mr_nf216 got %b,%0d want 1,0", s_nf, s_fc);
        else n_pass++;
        goto(217);
        n_chk++;
        if (s_fc !== 6'd1)
            $display("FAIL mr_fc217 got %0d want 1", s_fc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_delay();
        test_frame_strobe();
        test_sync_windows();
        test_default_raster();
        test_fc_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
